// File: rtl/quadrilatero_dispatcher_if.sv
// quadrilatero_dispatcher_if: decoder-side and functional-unit-side buses of the dispatcher
interface quadrilatero_dispatcher_if #(
    parameter int N_REGS    = 8,
    parameter int MAX_READS = 3,
    parameter int ID_WIDTH  = 4
);
    localparam int RW = $clog2(N_REGS);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_legal;
    logic [ID_WIDTH-1:0]     in_id;
    logic [1:0]              in_n_reads;
    logic [MAX_READS*RW-1:0] in_read_regs;
    logic                    in_wb;
    logic [RW-1:0]           in_wb_reg;
    logic [1:0]              in_exec_unit;
    logic [1:0]              in_datatype;
    logic                    in_is_store;
    logic                    in_is_float;
    logic                    illegal;
    logic [2:0]              issue_valid;
    logic [2:0]              issue_ready;
    logic [ID_WIDTH-1:0]     issue_id;
    logic [1:0]              issue_n_reads;
    logic [MAX_READS*RW-1:0] issue_read_regs;
    logic [RW-1:0]           issue_wb_reg;
    logic [1:0]              issue_datatype;
    logic                    issue_is_store;
    logic                    issue_is_float;
    logic [2:0]              rd_rel_valid;
    logic [3*RW-1:0]         rd_rel_reg;
    logic [2:0]              wb_rel_valid;
    logic [3*RW-1:0]         wb_rel_reg;
    logic                    busy;
    // master: decoder plus functional units; slave: the dispatcher itself
    modport master (
        output in_valid, in_legal, in_id, in_n_reads, in_read_regs, in_wb, in_wb_reg,
               in_exec_unit, in_datatype, in_is_store, in_is_float, issue_ready,
               rd_rel_valid, rd_rel_reg, wb_rel_valid, wb_rel_reg,
        input  in_ready, illegal, issue_valid, issue_id, issue_n_reads, issue_read_regs,
               issue_wb_reg, issue_datatype, issue_is_store, issue_is_float, busy
    );
    modport slave (
        input  in_valid, in_legal, in_id, in_n_reads, in_read_regs, in_wb, in_wb_reg,
               in_exec_unit, in_datatype, in_is_store, in_is_float, issue_ready,
               rd_rel_valid, rd_rel_reg, wb_rel_valid, wb_rel_reg,
        output in_ready, illegal, issue_valid, issue_id, issue_n_reads, issue_read_regs,
               issue_wb_reg, issue_datatype, issue_is_store, issue_is_float, busy
    );
endinterface

// File: rtl/quadrilatero_dispatcher.sv
// quadrilatero_dispatcher: scoreboarded single-entry issue stage for matrix instructions
module quadrilatero_dispatcher #(
    parameter int N_REGS     = 8,
    parameter int MAX_READS  = 3,
    parameter int RD_CNT_MAX = 3,
    parameter int ID_WIDTH   = 4
) (
    input logic clk_i,
    input logic rst_i,
    quadrilatero_dispatcher_if.slave bus
);
    localparam int RW = $clog2(N_REGS);
    localparam int CW = $clog2(RD_CNT_MAX + 1);
    localparam int SW = CW + 2;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     id_q;
    logic [1:0]              n_reads_q;
    logic [MAX_READS*RW-1:0] read_regs_q;
    logic [RW-1:0]           wb_reg_q;
    logic [1:0]              unit_q;
    logic [1:0]              datatype_q;
    logic                    is_store_q;
    logic                    is_float_q;
    logic                    illegal_q;
    logic [N_REGS-1:0]       pend_wr_q, pend_wr_d, wb_set, wb_clr;
    logic [CW-1:0]           rd_cnt_q [N_REGS];
    logic [CW-1:0]           rd_cnt_d [N_REGS];
    logic [1:0]              rd_inc [N_REGS];
    logic [1:0]              rd_dec [N_REGS];
    logic [SW-1:0]           rd_sum [N_REGS];
    logic [SW-1:0]           rd_net [N_REGS];
    logic                    hazard, self_read, fire, accept, load, illegal_d, sb_busy;

    assign bus.issue_valid     = (state_q == FULL) ? 3'(3'b001 << unit_q) : 3'b000;
    assign fire                = |(bus.issue_valid & bus.issue_ready);
    assign bus.in_ready        = (state_q == EMPTY || fire) && !hazard;
    assign bus.illegal         = illegal_q;
    assign bus.issue_id        = id_q;
    assign bus.issue_n_reads   = n_reads_q;
    assign bus.issue_read_regs = read_regs_q;
    assign bus.issue_wb_reg    = wb_reg_q;
    assign bus.issue_datatype  = datatype_q;
    assign bus.issue_is_store  = is_store_q;
    assign bus.issue_is_float  = is_float_q;
    assign bus.busy            = (state_q == FULL) || sb_busy;

    // Hazard check against the registered scoreboard only; same-cycle releases are not seen
    always_comb begin
        hazard    = 1'b0;
        self_read = 1'b0;
        for (int k = 0; k < MAX_READS; k++) begin
            if (2'(k) < bus.in_n_reads) begin
                if (pend_wr_q[bus.in_read_regs[k*RW +: RW]] ||
                    rd_cnt_q[bus.in_read_regs[k*RW +: RW]] == CW'(RD_CNT_MAX))
                    hazard = 1'b1;
                if (bus.in_read_regs[k*RW +: RW] == bus.in_wb_reg)
                    self_read = 1'b1;
            end
        end
        if (bus.in_wb && (pend_wr_q[bus.in_wb_reg] ||
                          (rd_cnt_q[bus.in_wb_reg] != '0 && !self_read)))
            hazard = 1'b1;
    end

    // Next-state: a legal accept fills the register, a completed transfer alone empties it
    always_comb begin
        accept    = bus.in_valid && bus.in_ready;
        load      = accept && bus.in_legal && bus.in_exec_unit != 2'd3;
        illegal_d = accept && !load;
        state_d   = load ? FULL : fire ? EMPTY : state_q;
    end

    // Scoreboard update: net of this cycle's accept increments and all FU releases
    always_comb begin
        sb_busy = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            rd_inc[i] = 2'd0;
            rd_dec[i] = 2'd0;
            wb_clr[i] = 1'b0;
            for (int k = 0; k < MAX_READS; k++)
                if (load && 2'(k) < bus.in_n_reads && bus.in_read_regs[k*RW +: RW] == RW'(i))
                    rd_inc[i] = rd_inc[i] + 2'd1;
            for (int f = 0; f < 3; f++) begin
                if (bus.rd_rel_valid[f] && bus.rd_rel_reg[f*RW +: RW] == RW'(i))
                    rd_dec[i] = rd_dec[i] + 2'd1;
                if (bus.wb_rel_valid[f] && bus.wb_rel_reg[f*RW +: RW] == RW'(i))
                    wb_clr[i] = 1'b1;
            end
            wb_set[i]   = load && bus.in_wb && bus.in_wb_reg == RW'(i);
            rd_sum[i]   = SW'(rd_cnt_q[i]) + SW'(rd_inc[i]);
            rd_net[i]   = rd_sum[i] - SW'(rd_dec[i]);
            rd_cnt_d[i] = (rd_sum[i] <= SW'(rd_dec[i])) ? '0 :
                          (rd_net[i] > SW'(RD_CNT_MAX)) ? CW'(RD_CNT_MAX) : CW'(rd_net[i]);
            sb_busy     = sb_busy || pend_wr_q[i] || rd_cnt_q[i] != '0;
        end
        pend_wr_d = wb_set | (pend_wr_q & ~wb_clr);
    end

    // State, issue register and scoreboard registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            id_q        <= '0;
            n_reads_q   <= '0;
            read_regs_q <= '0;
            wb_reg_q    <= '0;
            unit_q      <= '0;
            datatype_q  <= '0;
            is_store_q  <= 1'b0;
            is_float_q  <= 1'b0;
            illegal_q   <= 1'b0;
            pend_wr_q   <= '0;
            for (int i = 0; i < N_REGS; i++) rd_cnt_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            pend_wr_q <= pend_wr_d;
            for (int i = 0; i < N_REGS; i++) rd_cnt_q[i] <= rd_cnt_d[i];
            if (load) begin
                id_q        <= bus.in_id;
                n_reads_q   <= bus.in_n_reads;
                read_regs_q <= bus.in_read_regs;
                wb_reg_q    <= bus.in_wb_reg;
                unit_q      <= bus.in_exec_unit;
                datatype_q  <= bus.in_datatype;
                is_store_q  <= bus.in_is_store;
                is_float_q  <= bus.in_is_float;
            end
        end
    end

    // Releases that find nothing outstanding are ignored in hardware but flagged here
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            for (int i = 0; i < N_REGS; i++) begin
                assert (SW'(rd_dec[i]) <= rd_sum[i])
                    else $error("read release on idle register %0d", i);
                assert (!wb_clr[i] || pend_wr_q[i])
                    else $error("writeback release on clear register %0d", i);
            end
    end
endmodule

// File: tb/tb_quadrilatero_dispatcher.sv
// tb_quadrilatero_dispatcher: directed cycle tables plus hand sequences for stalls, hold and saturation
module tb_quadrilatero_dispatcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    quadrilatero_dispatcher_if bus ();

    quadrilatero_dispatcher dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        string name;
        int v, lg, id, nr, rr, wb, wr, eu, rdy, rrv, rrr, wrv, wrr;
        int e_rdy, e_ill, e_iv, e_id, e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic int regs3(int a, int b, int c);
        return (c << 6) | (b << 3) | a;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(int v, int lg, int id, int nr, int rr, int wb, int wr, int eu,
                         int rdy, int rrv, int rrr, int wrv, int wrr);
        bus.in_valid     = 1'(v);
        bus.in_legal     = 1'(lg);
        bus.in_id        = 4'(id);
        bus.in_n_reads   = 2'(nr);
        bus.in_read_regs = 9'(rr);
        bus.in_wb        = 1'(wb);
        bus.in_wb_reg    = 3'(wr);
        bus.in_exec_unit = 2'(eu);
        bus.in_datatype  = 2'd0;
        bus.in_is_store  = 1'b0;
        bus.in_is_float  = 1'b0;
        bus.issue_ready  = 3'(rdy);
        bus.rd_rel_valid = 3'(rrv);
        bus.rd_rel_reg   = 9'(rrr);
        bus.wb_rel_valid = 3'(wrv);
        bus.wb_rel_reg   = 9'(wrr);
    endtask

    task automatic idle(int rdy, int rrv, int rrr, int wrv, int wrr);
        drive(0, 1, 0, 0, 0, 0, 0, 0, rdy, rrv, rrr, wrv, wrr);
    endtask

    task automatic store4(int id);
        drive(1, 1, id, 1, regs3(4, 0, 0), 0, 0, 1, 'b111, 0, 0, 0, 0);
        bus.in_is_store = 1'b1;
    endtask

    initial begin
        //            name          v lg id nr rr               wb wr eu rdy    rrv    rrr              wrv    wrr              rdy ill iv     id busy
        tbl.push_back('{"mzero",      1, 1, 1, 0, 0,               1, 2, 2, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 0, 0});
        tbl.push_back('{"mld_r1",     1, 1, 2, 0, 0,               1, 1, 1, 'b111, 0,     0,               0,     0,               1, 0, 'b100, 1, 1});
        tbl.push_back('{"raw_stall0", 1, 1, 3, 3, regs3(1, 2, 0),  1, 0, 0, 'b111, 0,     0,               'b100, regs3(0, 0, 2),  0, 0, 'b010, 2, 1});
        tbl.push_back('{"raw_stall1", 1, 1, 3, 3, regs3(1, 2, 0),  1, 0, 0, 'b111, 0,     0,               'b010, regs3(0, 1, 0),  0, 0, 'b000, 2, 1});
        tbl.push_back('{"raw_go",     1, 1, 3, 3, regs3(1, 2, 0),  1, 0, 0, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 2, 0});
        tbl.push_back('{"mmacc_sa",   0, 1, 0, 0, 0,               0, 0, 0, 'b111, 0,     0,               0,     0,               1, 0, 'b001, 3, 1});
        tbl.push_back('{"rel_all",    0, 1, 0, 0, 0,               0, 0, 0, 'b111, 'b111, regs3(1, 2, 0),  'b001, 0,               1, 0, 'b000, 3, 1});
        tbl.push_back('{"idle0",      0, 1, 0, 0, 0,               0, 0, 0, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 3, 0});
        tbl.push_back('{"mst_r3",     1, 1, 4, 1, regs3(3, 0, 0),  0, 0, 1, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 3, 0});
        tbl.push_back('{"war_stall0", 1, 1, 5, 0, 0,               1, 3, 1, 'b111, 0,     0,               0,     0,               0, 0, 'b010, 4, 1});
        tbl.push_back('{"war_stall1", 1, 1, 5, 0, 0,               1, 3, 1, 'b111, 'b010, regs3(0, 3, 0),  0,     0,               0, 0, 'b000, 4, 1});
        tbl.push_back('{"war_go",     1, 1, 5, 0, 0,               1, 3, 1, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 4, 0});
        tbl.push_back('{"mld_r3_iss", 0, 1, 0, 0, 0,               0, 0, 0, 'b111, 0,     0,               'b010, regs3(0, 3, 0),  1, 0, 'b010, 5, 1});
        tbl.push_back('{"idle1",      0, 1, 0, 0, 0,               0, 0, 0, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 5, 0});
        tbl.push_back('{"illegal",    1, 0, 6, 1, regs3(5, 0, 0),  1, 5, 0, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 5, 0});
        tbl.push_back('{"ill_pulse",  0, 1, 0, 0, 0,               0, 0, 0, 'b111, 0,     0,               0,     0,               1, 1, 'b000, 5, 0});
        tbl.push_back('{"ill_clear",  0, 1, 0, 0, 0,               0, 0, 0, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 5, 0});
        tbl.push_back('{"unit3",      1, 1, 7, 0, 0,               1, 6, 3, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 5, 0});
        tbl.push_back('{"unit3_pulse",0, 1, 0, 0, 0,               0, 0, 0, 'b111, 0,     0,               0,     0,               1, 1, 'b000, 5, 0});
        tbl.push_back('{"mld_r6",     1, 1, 8, 0, 0,               1, 6, 1, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 5, 0});
        tbl.push_back('{"mld_r6_iss", 0, 1, 0, 0, 0,               0, 0, 0, 'b111, 0,     0,               'b010, regs3(0, 6, 0),  1, 0, 'b010, 8, 1});
        tbl.push_back('{"idle2",      0, 1, 0, 0, 0,               0, 0, 0, 'b111, 0,     0,               0,     0,               1, 0, 'b000, 8, 0});

        idle(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset/issue_valid", 32'(bus.issue_valid), 0);
        chk("reset/illegal", 32'(bus.illegal), 0);
        chk("reset/busy", 32'(bus.busy), 0);
        chk("reset/issue_id", 32'(bus.issue_id), 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].lg, tbl[i].id, tbl[i].nr, tbl[i].rr, tbl[i].wb, tbl[i].wr,
                  tbl[i].eu, tbl[i].rdy, tbl[i].rrv, tbl[i].rrr, tbl[i].wrv, tbl[i].wrr);
            #1;
            chk({tbl[i].name, "/in_ready"}, 32'(bus.in_ready), tbl[i].e_rdy);
            chk({tbl[i].name, "/illegal"}, 32'(bus.illegal), tbl[i].e_ill);
            chk({tbl[i].name, "/issue_valid"}, 32'(bus.issue_valid), tbl[i].e_iv);
            chk({tbl[i].name, "/issue_id"}, 32'(bus.issue_id), tbl[i].e_id);
            chk({tbl[i].name, "/busy"}, 32'(bus.busy), tbl[i].e_busy);
        end

        // SA back-pressure: payload must hold, then transfer and new accept share one cycle
        @(negedge clk);
        drive(1, 1, 9, 2, regs3(0, 1, 0), 1, 2, 0, 'b110, 0, 0, 0, 0);
        bus.in_datatype = 2'd2;
        bus.in_is_float = 1'b1;
        #1;
        chk("mmaqa/in_ready", 32'(bus.in_ready), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(1, 1, 10, 0, 0, 1, 5, 2, 'b110, 0, 0, 0, 0);
            #1;
            chk("hold/issue_valid", 32'(bus.issue_valid), 'b001);
            chk("hold/issue_id", 32'(bus.issue_id), 9);
            chk("hold/read_regs", 32'(bus.issue_read_regs), regs3(0, 1, 0));
            chk("hold/n_reads", 32'(bus.issue_n_reads), 2);
            chk("hold/wb_reg", 32'(bus.issue_wb_reg), 2);
            chk("hold/datatype", 32'(bus.issue_datatype), 2);
            chk("hold/is_float", 32'(bus.issue_is_float), 1);
            chk("hold/in_ready", 32'(bus.in_ready), 0);
        end
        @(negedge clk);
        drive(1, 1, 10, 0, 0, 1, 5, 2, 'b111, 0, 0, 0, 0);
        #1;
        chk("b2b/in_ready", 32'(bus.in_ready), 1);
        chk("b2b/issue_id", 32'(bus.issue_id), 9);
        @(negedge clk);
        idle('b111, 'b011, regs3(0, 1, 0), 'b101, regs3(2, 0, 5));
        #1;
        chk("b2b_next/issue_valid", 32'(bus.issue_valid), 'b100);
        chk("b2b_next/issue_id", 32'(bus.issue_id), 10);
        chk("b2b_next/datatype", 32'(bus.issue_datatype), 0);
        @(negedge clk);
        idle('b111, 0, 0, 0, 0);
        #1;
        chk("b2b_clean/busy", 32'(bus.busy), 0);
        chk("b2b_clean/issue_valid", 32'(bus.issue_valid), 0);

        // Read-counter saturation on reg 4 and multi-FU release netted with an accept
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            store4(11 + s);
            #1;
            chk("sat_fill/in_ready", 32'(bus.in_ready), 1);
        end
        @(negedge clk);
        store4(14);
        #1;
        chk("sat_full/in_ready", 32'(bus.in_ready), 0);
        chk("sat_full/issue_id", 32'(bus.issue_id), 13);
        chk("sat_full/is_store", 32'(bus.issue_is_store), 1);
        @(negedge clk);
        store4(14);
        bus.rd_rel_valid = 3'b001;
        bus.rd_rel_reg   = 9'(regs3(4, 0, 0));
        #1;
        chk("sat_rel1/in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        store4(14);
        bus.rd_rel_valid = 3'b011;
        bus.rd_rel_reg   = 9'(regs3(4, 4, 0));
        #1;
        chk("sat_net/in_ready", 32'(bus.in_ready), 1);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            store4(15 + s);
            #1;
            chk("sat_refill/in_ready", 32'(bus.in_ready), 1);
            chk("sat_refill/issue_id", 32'(bus.issue_id), 14 + s);
        end
        @(negedge clk);
        store4(1);
        #1;
        chk("sat_again/in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        idle('b111, 'b111, regs3(4, 4, 4), 0, 0);
        #1;
        chk("sat_drain/issue_valid", 32'(bus.issue_valid), 0);
        chk("sat_drain/busy", 32'(bus.busy), 1);
        @(negedge clk);
        idle('b111, 0, 0, 0, 0);
        #1;
        chk("sat_clean/busy", 32'(bus.busy), 0);

        // Reset with an instruction held and a write pending discards everything
        @(negedge clk);
        drive(1, 1, 1, 0, 0, 1, 7, 1, 'b000, 0, 0, 0, 0);
        #1;
        chk("mid/in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        idle('b000, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("mid/issue_valid", 32'(bus.issue_valid), 'b010);
        @(negedge clk);
        #1;
        chk("mid_rst/issue_valid", 32'(bus.issue_valid), 0);
        chk("mid_rst/busy", 32'(bus.busy), 0);
        chk("mid_rst/issue_id", 32'(bus.issue_id), 0);
        rst = 1'b0;
        @(negedge clk);
        drive(1, 1, 2, 0, 0, 1, 7, 1, 'b111, 0, 0, 0, 0);
        #1;
        chk("post_rst/in_ready", 32'(bus.in_ready), 1);
        chk("post_rst/busy", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
